t_inverter_array: RTL and testbench
===================================

# t_inverter_array

Parametrised, pipelined ternary unary-logic unit. It applies one of four per-word selectable inversions to a vector of N_TRITS binary-coded trits behind a valid/ready handshake. Invalid trit encodings are flagged and counted. It is the vector successor to the single-trit DLFET-RM inverter and sits between ternary register-file read ports and downstream ALU stages.

## Interface
- N_TRITS, 8: trits per word; legal range 1..64.
- CNT_W, 16: error counter width; legal range 2..32.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  unit can accept an input word this cycle.
- in_data  in  2*N_TRITS  trit i at bits [2i+1:2i]; encodings 00=0, 01=1, 10=2, 11=invalid.
- in_mode  in  2  operation for this word: 00 STI, 01 NTI, 10 PTI, 11 BUF.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  2*N_TRITS  result word, same packing as in_data.
- out_err  out  N_TRITS  bit i set when input trit i was invalid (11).
- err_clr  in  1  clears err_count.
- err_count  out  CNT_W  saturating count of accepted words with at least one invalid trit.

## Operation
- Per-trit mapping, applied independently to every trit of the accepted word:
  - STI: 0→2, 1→1, 2→0.
  - NTI: 0→2, 1→0, 2→0.
  - PTI: 0→2, 1→2, 2→0.
  - BUF: 0→0, 1→1, 2→2.
  - Invalid input 11 in any mode → output 01 (state 1, the RM-stabilised default), with out_err[i]=1.
- The output never carries the 11 encoding.
- Single output register holds out_data, out_err and out_valid.
- Accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !out_valid || out_ready, combinational. Full throughput of one word per cycle while out_ready=1.
- On accept, the output register loads the mapped word and out_err, and out_valid goes to 1.
- On a transfer with no accept in the same cycle, out_valid goes to 0 and data is held, don't-care.
- Simultaneous transfer and accept: the register loads the new word and out_valid stays 1.
- While out_valid=1 and out_ready=0: out_data, out_err and out_valid are held stable. in_ready=0, so nothing is accepted.
- in_mode is sampled only on accept. Mode changes between words are legal with no bubble.
- err_count:
  - Increments by 1 on each accept whose word has any invalid trit.
  - Saturates at 2^CNT_W−1 and never wraps.
  - err_clr=1 sets the count to 0 next cycle and takes priority over a same-cycle increment; that event is not counted.

## Timing
- Reset values: out_valid=0, out_data=0, out_err=0, err_count=0. in_ready=1 in the first cycle after reset.
- Reset applied mid-operation discards any held word, even one with out_ready=0, and no transfer is reported for it.
- Inputs are ignored in any cycle with rst=1.
- Latency: a word accepted at edge k appears with out_valid=1 after edge k, and can transfer at edge k+1.
- err_count reflects an accept at edge k after that same edge.
- No combinational path from in_data, in_mode or in_valid to any output. The only combinational output path is out_ready→in_ready.

## Test plan
- Reset, then N_TRITS=8, STI, in_data=16'b10_01_00_10_01_00_10_01 → out_data=16'b00_01_10_00_01_10_00_01, out_err=0, out_valid one cycle after accept.
- Same trit vector {0,1,2} sent with NTI, PTI, BUF on back-to-back cycles, out_ready=1 → outputs {2,0,0}, {2,2,0}, {0,1,2} on consecutive cycles with no bubbles.
- in_data with trits 0 and 5 = 11, STI → those trits output 01, out_err=8'b0010_0001, err_count 0→1.
- out_ready=0 for 5 cycles with out_valid=1 → in_ready=0 and out_data/out_err stable. Release → transfer, then the pending input is accepted in the same cycle.
- CNT_W=2: send 5 error words → err_count 1,2,3,3,3. err_clr on the same cycle as an error word → err_count=0.
- Assert rst while out_valid=1, out_ready=0 → next cycle out_valid=0, err_count=0, in_ready=1.

Source files
------------

// File: rtl/t_inverter_array.sv
// rtl/t_inverter_array.sv - pipelined ternary inverter array (STI/NTI/PTI/BUF) with invalid-trit tracking
module t_inverter_array #(
    parameter int N_TRITS = 8,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*N_TRITS-1:0]   in_data,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*N_TRITS-1:0]   out_data,
    output logic [N_TRITS-1:0]     out_err,
    input  logic                   err_clr,
    output logic [CNT_W-1:0]       err_count
);

    typedef enum logic [1:0] {
        MODE_STI = 2'b00,
        MODE_NTI = 2'b01,
        MODE_PTI = 2'b10,
        MODE_BUF = 2'b11
    } mode_t;

    // Invalid encodings collapse to state 1, so 2'b11 can never leave the unit.
    function automatic logic [1:0] map_trit(input logic [1:0] t, input mode_t m);
        logic [1:0] r;
        r = 2'b01;
        if (t != 2'b11) begin
            case (m)
                MODE_STI: r = (t == 2'b00) ? 2'b10 : (t == 2'b01) ? 2'b01 : 2'b00;
                MODE_NTI: r = (t == 2'b00) ? 2'b10 : 2'b00;
                MODE_PTI: r = (t == 2'b10) ? 2'b00 : 2'b10;
                MODE_BUF: r = t;
                default:  r = 2'b01;
            endcase
        end
        return r;
    endfunction

    logic [2*N_TRITS-1:0] mapped;
    logic [N_TRITS-1:0]   bad;
    logic                 accept;
    logic                 xfer;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    always_comb begin
        mapped = '0;
        bad    = '0;
        for (int i = 0; i < N_TRITS; i++) begin
            mapped[2*i +: 2] = map_trit(in_data[2*i +: 2], mode_t'(in_mode));
            bad[i]           = (in_data[2*i +: 2] == 2'b11);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mapped;
            out_err   <= bad;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Clear beats a same-cycle increment; the counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (accept && (|bad) && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_t_inverter_array.sv
// tb/tb_t_inverter_array.sv - randomized and directed bench for t_inverter_array
module tb_t_inverter_array;

    localparam int N  = 8;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2*N-1:0]  in_data;
    logic [1:0]      in_mode;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  out_data;
    logic [N-1:0]    out_err;
    logic            err_clr;
    logic [CW-1:0]   err_count;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    typedef struct {
        logic [2*N-1:0] d;
        logic [N-1:0]   e;
    } word_t;

    word_t q[$];
    int    exp_cnt = 0;

    always #5 clk = ~clk;

    t_inverter_array #(.N_TRITS(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_count (err_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: trit values as integers, mapping written as arithmetic rules.
    function automatic word_t ref_word(input logic [2*N-1:0] d, input logic [1:0] m);
        word_t w;
        int t;
        int r;
        w.d = '0;
        w.e = '0;
        for (int i = 0; i < N; i++) begin
            t = int'(d[2*i +: 2]);
            if (t == 3) begin
                r = 1;
                w.e[i] = 1'b1;
            end else begin
                case (m)
                    2'd0:    r = 2 - t;
                    2'd1:    r = (t == 0) ? 2 : 0;
                    2'd2:    r = (t == 2) ? 0 : 2;
                    default: r = t;
                endcase
            end
            w.d[2*i +: 2] = 2'(r);
        end
        return w;
    endfunction

    always @(negedge clk) begin
        bit mv;
        bit acc;
        word_t w;
        if (rst) begin
            q.delete();
            exp_cnt = 0;
        end else if (started) begin
            mv = (q.size() != 0);
            chk("in_ready", 64'(in_ready), 64'(!mv || out_ready));
            chk("out_valid", 64'(out_valid), 64'(mv));
            if (mv) begin
                chk("out_data", 64'(out_data), 64'(q[0].d));
                chk("out_err", 64'(out_err), 64'(q[0].e));
            end
            chk("err_count", 64'(err_count), 64'(exp_cnt));
            acc = in_valid && (!mv || out_ready);
            if (mv && out_ready) void'(q.pop_front());
            if (acc) begin
                w = ref_word(in_data, in_mode);
                q.push_back(w);
            end
            if (err_clr) exp_cnt = 0;
            else if (acc && (|w.e) && exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
    end

    task automatic step(input logic r, input logic v, input logic [2*N-1:0] d,
                        input logic [1:0] m, input logic ordy, input logic clr);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        out_ready = ordy;
        err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    logic [2*N-1:0] w012;
    logic [2*N-1:0] werr;
    logic [2*N-1:0] rd;

    initial begin
        w012 = 16'b01_00_10_01_00_10_01_00;
        werr = 16'b00_00_11_00_00_00_00_11;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0; err_clr = 1'b0;
        step(1, 0, '0, 0, 0, 0);
        step(1, 0, '0, 0, 0, 0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        started = 1'b1;

        step(0, 1, 16'b10_01_00_10_01_00_10_01, 2'd0, 1, 0);
        chk("sti_valid", 64'(out_valid), 64'd1);
        chk("sti_data", 64'(out_data), 64'(16'b00_01_10_00_01_10_00_01));
        chk("sti_err", 64'(out_err), 64'd0);

        step(0, 1, w012, 2'd1, 1, 0);
        chk("nti_data", 64'(out_data), 64'(16'b00_10_00_00_10_00_00_10));
        step(0, 1, w012, 2'd2, 1, 0);
        chk("pti_valid", 64'(out_valid), 64'd1);
        chk("pti_data", 64'(out_data), 64'(16'b10_10_00_10_10_00_10_10));
        step(0, 1, w012, 2'd3, 1, 0);
        chk("buf_valid", 64'(out_valid), 64'd1);
        chk("buf_data", 64'(out_data), 64'(w012));

        step(0, 1, werr, 2'd0, 1, 0);
        chk("inv_data", 64'(out_data), 64'(16'b10_10_01_10_10_10_10_01));
        chk("inv_err", 64'(out_err), 64'(8'b0010_0001));
        chk("inv_count", 64'(err_count), 64'd1);

        for (int i = 0; i < 5; i++) begin
            step(0, 1, w012, 2'd3, 0, 0);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_data", 64'(out_data), 64'(16'b10_10_01_10_10_10_10_01));
            chk("stall_err", 64'(out_err), 64'(8'b0010_0001));
        end
        step(0, 1, w012, 2'd3, 1, 0);
        chk("release_data", 64'(out_data), 64'(w012));
        chk("release_err", 64'(out_err), 64'd0);

        step(0, 0, '0, 0, 1, 1);
        chk("clr_count", 64'(err_count), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, werr, 2'(i), 1, 0);
            chk("sat_count", 64'(err_count), 64'((i < 3) ? i + 1 : 3));
        end
        step(0, 1, werr, 2'd0, 1, 1);
        chk("clr_prio_count", 64'(err_count), 64'd0);

        step(0, 0, '0, 0, 1, 0);
        step(0, 1, werr, 2'd2, 1, 0);
        chk("pre_rst_count", 64'(err_count), 64'd1);
        step(1, 1, werr, 2'd2, 0, 0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(err_count), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++)
                rd[2*i +: 2] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rd,
                 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0));
        end
        step(0, 0, '0, 0, 1, 0);
        step(0, 0, '0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
